// File: rtl/mont_premul_seq.sv
// rtl/mont_premul_seq.sv - shift-add pre-multiplier t = x*rmm feeding the Montgomery reducer
// Optional MONT_PREMUL_ZERO_SKIP_EN: finish MUL as soon as the remaining multiplier bits are zero.
module mont_premul_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   x,
  input  logic [DATA_WIDTH-1:0]   rmm,
  input  logic [DATA_WIDTH-1:0]   modulant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] t,
  output logic [DATA_WIDTH-1:0]   out_modulant,
  output logic [DATA_WIDTH-1:0]   bit_length,
  output logic                    err,
  output logic                    busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state, state_nxt;
  logic [2*W-1:0]  acc, mcand, acc_sum;
  logic [W-1:0]    mplier, mplier_nxt;
  logic [CW-1:0]   cnt;
  logic            last_step;

  function automatic logic [W-1:0] msb_len(input logic [W-1:0] v);
    msb_len = '0;
    for (int i = 0; i < W; i++)
      if (v[i]) msb_len = W'(i + 1);
  endfunction

  assign acc_sum    = mplier[0] ? acc + mcand : acc;
  assign mplier_nxt = mplier >> 1;

`ifdef MONT_PREMUL_ZERO_SKIP_EN
  // Once no multiplier bits remain the accumulator is already final.
  assign last_step = (mplier_nxt == '0) || (cnt == CW'(W - 1));
`else
  assign last_step = (cnt == CW'(W - 1));
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = modulant[0] ? MUL : DONE;
      MUL:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      cnt          <= '0;
      t            <= '0;
      out_modulant <= '0;
      bit_length   <= '0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_modulant <= modulant;
            bit_length   <= msb_len(modulant);
            if (!modulant[0]) begin
              err <= 1'b1;
              t   <= '0;
            end else begin
              err    <= 1'b0;
              acc    <= '0;
              mcand  <= {{W{1'b0}}, x};
              mplier <= rmm;
              cnt    <= '0;
            end
          end
        end
        MUL: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier_nxt;
          cnt    <= cnt + 1'b1;
          if (last_step) t <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_premul_seq.sv
// tb/tb_mont_premul_seq.sv - vector table plus scoreboard bench for mont_premul_seq
module tb_mont_premul_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, err, busy;
  logic [7:0]  x, rmm, modulant, out_modulant, bit_length;
  logic [15:0] t;

  mont_premul_seq #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .rmm(rmm), .modulant(modulant), .out_valid(out_valid),
    .out_ready(out_ready), .t(t), .out_modulant(out_modulant),
    .bit_length(bit_length), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x, rmm, m;
    logic [15:0] t;
    logic [7:0]  bl;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] t;
    logic [7:0]  bl, m;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int len_of(input logic [7:0] v);
    int n = 0;
    while (v != 0) begin n++; v = v >> 1; end
    return n;
  endfunction

  function automatic int lat_of(input logic [7:0] r, input logic e);
    if (e) return 0;
`ifdef MONT_PREMUL_ZERO_SKIP_EN
    return (len_of(r) == 0) ? 1 : len_of(r);
`else
    return 8;
`endif
  endfunction

  // Drives one operation and compares against the scoreboard head; leaves DUT in DONE.
  task automatic run_op(input logic [7:0] xi, input logic [7:0] ri, input logic [7:0] mi,
                        input logic [15:0] et, input logic [7:0] ebl, input logic ee);
    exp_t e, g;
    int   lat;
    check("in_ready_idle", in_ready, 1);
    x = xi; rmm = ri; modulant = mi; in_valid = 1'b1;
    e.t = et; e.bl = ebl; e.m = mi; e.err = ee; e.lat = lat_of(ri, ee);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      check("busy_mul", {busy, in_ready}, 2'b10);
      x = 8'($urandom); rmm = 8'($urandom); modulant = 8'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    g = sb.pop_front();
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", lat, g.lat);
    check("t", t, g.t);
    check("bit_length", bit_length, g.bl);
    check("err", err, g.err);
    check("out_modulant", out_modulant, g.m);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{8'h05, 8'h0C, 8'h0D, 16'h003C, 8'd4, 1'b0};
    vt[1] = '{8'hFF, 8'hFF, 8'hFF, 16'hFE01, 8'd8, 1'b0};
    vt[2] = '{8'h05, 8'h0C, 8'h0C, 16'h0000, 8'd4, 1'b1};
    vt[3] = '{8'h07, 8'h03, 8'h0D, 16'h0015, 8'd4, 1'b0};
    vt[4] = '{8'h07, 8'h00, 8'h0D, 16'h0000, 8'd4, 1'b0};
    vt[5] = '{8'h00, 8'hFF, 8'h01, 16'h0000, 8'd1, 1'b0};
    vt[6] = '{8'hFF, 8'h80, 8'h81, 16'h7F80, 8'd8, 1'b0};
    vt[7] = '{8'h12, 8'h34, 8'h00, 16'h0000, 8'd0, 1'b1};
    vt[8] = '{8'hAB, 8'hCD, 8'h03, 16'h88EF, 8'd2, 1'b0};
    vt[9] = '{8'h01, 8'h01, 8'h80, 16'h0000, 8'd8, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; rmm = '0; modulant = '0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_t", t, 0);
    check("rst_modulant", out_modulant, 0);
    check("rst_bit_length", bit_length, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].x, vt[i].rmm, vt[i].m, vt[i].t, vt[i].bl, vt[i].err);
      consume();
    end

    for (int i = 0; i < 16; i++) begin
      logic [7:0] rx, rr, rm;
      logic       re;
      rx = 8'($urandom); rr = 8'($urandom); rm = 8'($urandom);
      if (i % 4 != 0) rm[0] = 1'b1;
      re = ~rm[0];
      run_op(rx, rr, rm, re ? 16'h0 : 16'(rx) * 16'(rr), 8'(len_of(rm)), re);
      consume();
    end

    // Backpressure: result held while inputs wiggle.
    out_ready = 1'b0;
    run_op(8'h05, 8'h0C, 8'h0D, 16'h003C, 8'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom); x = 8'($urandom); rmm = 8'($urandom); modulant = 8'($urandom);
      @(posedge clk); #1;
      check("bp_hold", {out_valid, in_ready, err, bit_length, out_modulant, t},
            {1'b1, 1'b0, 1'b0, 8'd4, 8'h0D, 16'h003C});
    end
    in_valid = 1'b0;
    consume();

    // Asynchronous reset during MUL step 3.
    x = 8'h05; rmm = 8'h0C; modulant = 8'h0D; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", {out_valid, busy, err, bit_length, out_modulant, t}, '0);
    check("arst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h05, 8'h0C, 8'h0D, 16'h003C, 8'd4, 1'b0);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
